serial_adder: RTL and testbench

- Bit-serial N-bit adder: captures two operands plus a carry-in on a start strobe, then adds one bit per clock, LSB first.
- Uses a single full-adder slice with a registered carry loop.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Sits between operand-producing control logic and result consumers; trades latency for area.

---
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder. Operands and carry-in are
// captured on an accepted start, then one full-adder slice retires one bit
// per clock, LSB first, through a registered carry loop. The sum and
// carry-out are registered at completion and held until the next one, with
// a single-cycle done pulse.

// One full-adder slice; the only arithmetic in the datapath.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (b & ci) | (ci & a);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] res_next;
  logic             accept;

  serial_adder_fa u_fa (
    .a  (opa[0]),
    .b  (opb[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = {s_bit, res[WIDTH-1:1]};

  // A request is taken in IDLE and on the closing edge of DONE (back-to-back).
  assign accept = start && (state != SHIFT);

  // Status decoded straight from the state register, no input paths.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // FSM, operand/result shifters, carry loop and completion registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          opa   <= {1'b0, opa[WIDTH-1:1]};
          opb   <= {1'b0, opb[WIDTH-1:1]};
          res   <= res_next;
          carry <= c_bit;
          if (cnt == LAST) begin
            // Counter parks at zero so it never runs past WIDTH-1.
            cnt   <= '0;
            sum   <= res_next;
            cout  <= c_bit;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IDLE, DONE: begin
          if (accept) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            res   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the 8-bit adder (reset, basic add,
// carry chain, busy protection, back-to-back, async reset mid-operation)
// followed by randomized regressions on 8-bit and 16-bit instances.
module tb_serial_adder;
  logic clk;
  logic rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic        start16;
  logic [15:0] a16, b16;
  logic        cin16;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1 with the 8-bit DUT in IDLE or DONE. Returns in the
  // done cycle (posedge+1) or with ok=0 after a cycle budget.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                     output logic [7:0] s, output logic co,
                     output int busy_n, output bit ok);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    busy_n = 0; ok = 0; s = '0; co = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy8) busy_n++;
      if (done8) begin s = sum8; co = cout8; ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic c,
                      output logic [15:0] s, output logic co, output bit ok);
    a16 = x; b16 = y; cin16 = c; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    ok = 0; s = '0; co = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done16) begin s = sum16; co = cout16; ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout8); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b done=%b want 0 0", busy8, done8);
    end
  endtask

  task automatic test_basic;
    logic [7:0] s; logic co; int bn; bit ok;
    op8(8'h3C, 8'h5A, 1'b0, s, co, bn, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done no done within budget"); end
    checks++; if (bn != 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bn); end
    checks++; if (s !== 8'h96) begin errors++; $display("FAIL basic_sum got %h want 96", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout got %b want 0", co); end
    @(posedge clk); #1;
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done8); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sum8 !== 8'h96 || cout8 !== 1'b0) begin
      errors++; $display("FAIL basic_hold got %h/%b want 96/0", sum8, cout8);
    end
  endtask

  task automatic test_carry_chain;
    logic [7:0] s; logic co; int bn; bit ok;
    op8(8'hFF, 8'h01, 1'b0, s, co, bn, ok);
    checks++; if (!ok || s !== 8'h00 || co !== 1'b1) begin
      errors++; $display("FAIL carry_ff_01 got %h/%b ok=%0d want 00/1", s, co, ok);
    end
    op8(8'hFF, 8'hFF, 1'b1, s, co, bn, ok);
    checks++; if (!ok || s !== 8'hFF || co !== 1'b1) begin
      errors++; $display("FAIL carry_ff_ff_1 got %h/%b ok=%0d want ff/1", s, co, ok);
    end
    op8(8'h00, 8'h00, 1'b1, s, co, bn, ok);
    checks++; if (!ok || s !== 8'h01 || co !== 1'b0) begin
      errors++; $display("FAIL carry_00_00_1 got %h/%b ok=%0d want 01/0", s, co, ok);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_protect;
    int dn = 0;
    logic [7:0] s = '0; logic co = 1'b0;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      start8 = (i == 2);
      if (i == 2) begin a8 = 8'hAA; b8 = 8'h55; end
      else begin a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); end
      if (done8) begin dn++; s = sum8; co = cout8; end
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    checks++; if (dn != 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", dn); end
    checks++; if (s !== 8'h30 || co !== 1'b0) begin
      errors++; $display("FAIL busy_result got %h/%b want 30/0", s, co);
    end
  endtask

  task automatic test_back_to_back;
    int t1 = -1, t2 = -1, stable_bad = 0;
    logic [7:0] s1 = '0, s2 = '0; logic c1 = 1'b0, c2 = 1'b0;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      if (done8 && t1 < 0) begin
        t1 = i; s1 = sum8; c1 = cout8;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
      end else if (done8 && t2 < 0) begin
        t2 = i; s2 = sum8; c2 = cout8; start8 = 1'b0;
        break;
      end else if (t1 >= 0 && busy8 && (sum8 !== 8'h02 || cout8 !== 1'b0)) begin
        stable_bad++;
      end
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    checks++; if (t1 < 0 || t2 < 0) begin errors++; $display("FAIL b2b_done missing t1=%0d t2=%0d", t1, t2); end
    checks++; if (t2 - t1 != 9) begin errors++; $display("FAIL b2b_spacing got %0d want 9", t2 - t1); end
    checks++; if (s1 !== 8'h02 || c1 !== 1'b0) begin errors++; $display("FAIL b2b_first got %h/%b want 02/0", s1, c1); end
    checks++; if (s2 !== 8'h00 || c2 !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b want 00/1", s2, c2); end
    checks++; if (stable_bad != 0) begin errors++; $display("FAIL b2b_sum_stable got %0d bad cycles want 0", stable_bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] s; logic co; int bn; bit ok; int dn = 0;
    op8(8'h3C, 8'h5A, 1'b0, s, co, bn, ok);
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done8); end
    checks++; if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++; $display("FAIL rstmid_sum got %h/%b want 00/0", sum8, cout8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) dn++;
      @(posedge clk); #1;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL rstmid_no_done got %0d active cycles want 0", dn); end
    op8(8'h7F, 8'h01, 1'b0, s, co, bn, ok);
    checks++; if (!ok || s !== 8'h80 || co !== 1'b0) begin
      errors++; $display("FAIL rstmid_fresh got %h/%b ok=%0d want 80/0", s, co, ok);
    end
  endtask

  task automatic test_random8;
    logic [7:0] x, y, s; logic c, co; logic [8:0] exp; int bn; bit ok;
    for (int n = 0; n < 1000; n++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      exp = {1'b0, x} + {1'b0, y} + {8'd0, c};
      op8(x, y, c, s, co, bn, ok);
      checks++;
      if (!ok || {co, s} !== exp) begin
        errors++; $display("FAIL rand8 %h+%h+%b got %b_%h want %h ok=%0d", x, y, c, co, s, exp, ok);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
  endtask

  task automatic test_random16;
    logic [15:0] x, y, s; logic c, co; logic [16:0] exp; bit ok;
    for (int n = 0; n < 1000; n++) begin
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
      exp = {1'b0, x} + {1'b0, y} + {16'd0, c};
      op16(x, y, c, s, co, ok);
      checks++;
      if (!ok || {co, s} !== exp) begin
        errors++; $display("FAIL rand16 %h+%h+%b got %b_%h want %h ok=%0d", x, y, c, co, s, exp, ok);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid();
    @(posedge clk); #1;
    test_random8();
    @(posedge clk); #1;
    test_random16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
